// File: rtl/c17_lane_pipe.sv
// c17_lane_pipe: multi-lane C17 evaluator behind an elastic valid/ready pipeline, with MISR signature and result counter.
// Build with FAULT_INJ_EN defined to add per-lane stuck-at fault injection ports (fi_en, fi_lane, fi_net, fi_val).
module c17_lane_pipe #(
   parameter int LANES = 4,
   parameter int PIPE = 2,
   parameter int SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY = SIG_W'(16'hB400),
   parameter int CNT_W = 16
) (
`ifdef FAULT_INJ_EN
   input  logic fi_en,
   input  logic [4:0] fi_lane,
   input  logic [2:0] fi_net,
   input  logic fi_val,
`endif
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  logic [5*LANES-1:0] in_data,
   output logic out_valid,
   input  logic out_ready,
   output logic [2*LANES-1:0] out_data,
   input  logic sig_en,
   input  logic sig_clr,
   output logic [SIG_W-1:0] signature,
   output logic [CNT_W-1:0] res_count
);
   localparam int DW = 2*LANES;
   localparam int NCH = (DW + SIG_W - 1) / SIG_W;
   // fm is a one-hot mask of the net forced to fv; downstream gates see the forced value
   function automatic logic [1:0] c17(input logic [4:0] g, input logic [5:0] fm, input logic fv);
      logic n7, n8, n9, n11, g22, g23;
      n7 = fm[0] ? fv : ~(g[2] & g[0]);
      n8 = fm[1] ? fv : ~(g[3] & g[2]);
      n9 = fm[2] ? fv : ~(n8 & g[1]);
      n11 = fm[3] ? fv : ~(n8 & g[4]);
      g22 = fm[4] ? fv : ~(n9 & n7);
      g23 = fm[5] ? fv : ~(n11 & n9);
      return {g23, g22};
   endfunction
   logic [DW-1:0] f;
   for (genvar k = 0; k < LANES; k++) begin : g_lane
`ifdef FAULT_INJ_EN
      logic [5:0] fm;
      assign fm = (fi_en && fi_lane == 5'(k) && fi_net < 3'd6) ? 6'd1 << fi_net : 6'd0;
      assign f[2*k +: 2] = c17(in_data[5*k +: 5], fm, fi_val);
`else
      assign f[2*k +: 2] = c17(in_data[5*k +: 5], 6'd0, 1'b0);
`endif
   end
   logic [PIPE-1:0] full, ld;
   for (genvar s = 0; s < PIPE; s++) begin : g_st
      logic vq, vi;
      logic [DW-1:0] dq, di;
      if (s == 0) begin : g_head
         assign vi = in_valid;
         assign di = f;
      end else begin : g_body
         assign vi = g_st[s-1].vq;
         assign di = g_st[s-1].dq;
      end
      // a stage can load if it or any stage ahead of it has room, or the sink drains this cycle
      assign ld[s] = out_ready || !(&full[PIPE-1:s]);
      assign full[s] = vq;
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            vq <= 1'b0;
            dq <= '0;
         end else if (ld[s]) begin
            vq <= vi;
            dq <= di;
         end
   end
   assign in_ready = ld[0];
   assign out_valid = full[PIPE-1];
   assign out_data = g_st[PIPE-1].dq;
   logic [NCH*SIG_W-1:0] ext;
   logic [SIG_W-1:0] fold, sig_nxt;
   logic hs;
   assign ext = (NCH*SIG_W)'(out_data);
   assign hs = out_valid && out_ready;
   always_comb begin
      fold = '0;
      for (int i = 0; i < NCH; i++) fold = fold ^ ext[i*SIG_W +: SIG_W];
      sig_nxt = (signature >> 1) ^ (signature[0] ? POLY : '0) ^ fold;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         signature <= '0;
         res_count <= '0;
      end else if (sig_clr) begin
         signature <= '0;
         res_count <= '0;
      end else if (hs) begin
         if (sig_en) signature <= sig_nxt;
         if (!(&res_count)) res_count <= res_count + 1'b1;
      end
endmodule
